// File: rtl/aes_cipher_iter_if.sv
// Block-in / result-out handshake bus of the iterative AES round engine,
// plus the combinational round-key lookup into the external key store.
interface aes_cipher_iter_if;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned RKNO_W = 4;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_mode;
    logic [RKNO_W-1:0] rk_no;
    logic [DATA_W-1:0] rk_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_mode;
    logic              busy;

    modport slave (
        input  in_valid, in_data, in_mode, rk_data, out_ready,
        output in_ready, rk_no, out_valid, out_data, out_mode, busy
    );

    modport master (
        output in_valid, in_data, in_mode, rk_data, out_ready,
        input  in_ready, rk_no, out_valid, out_data, out_mode, busy
    );
endinterface

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128/192/256 engine: one round per clock on a 128-bit state,
// optional inverse cipher, round keys fetched by index from an external store.
module aes_cipher_iter #(
    parameter int unsigned KEY_S      = 128,
    parameter bit          ENABLE_DEC = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    aes_cipher_iter_if.slave bus
);
    localparam int unsigned NR   = (KEY_S == 256) ? 14 : (KEY_S == 192) ? 12 : 10;
    localparam logic [3:0]  NR_B = 4'(NR);

    // Row-major table: entry 0 sits in the top byte, so entry b is at (255-b)*8.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] a2, a4, a8;
        a2 = xtime(a);
        a4 = xtime(a2);
        a8 = xtime(a4);
        return (c[0] ? a : 8'h00) ^ (c[1] ? a2 : 8'h00) ^ (c[2] ? a4 : 8'h00) ^ (c[3] ? a8 : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = SBOX[{~s[8*i +: 8], 3'b000} +: 8];
        return r;
    endfunction

    // Byte 4c+r is row r of column c; row r rotates left (or right) by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                r[8*(4*c+rw) +: 8] = s[8*(4*((c+rw)%4)+rw) +: 8];
        return r;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                r[8*(4*c+rw) +: 8] = s[8*(4*((c+4-rw)%4)+rw) +: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a3, a2, a1, a0} = s[32*c +: 32];
            r[32*c +: 32] = {gmul(a0, 4'h3) ^ a1 ^ a2 ^ gmul(a3, 4'h2),
                             a0 ^ a1 ^ gmul(a2, 4'h2) ^ gmul(a3, 4'h3),
                             a0 ^ gmul(a1, 4'h2) ^ gmul(a2, 4'h3) ^ a3,
                             gmul(a0, 4'h2) ^ gmul(a1, 4'h3) ^ a2 ^ a3};
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a3, a2, a1, a0} = s[32*c +: 32];
            r[32*c +: 32] = {gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he),
                             gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                             gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                             gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9)};
        end
        return r;
    endfunction

    state_e       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic         mode_q, mode_d;
    logic [127:0] blk_q, blk_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;
    logic         in_ready_c, accept_c;
    logic [127:0] enc_sr, enc_next, dec_next, round_next;

    // Forward round: the final round skips MixColumns.
    always_comb begin
        enc_sr     = shift_rows(sub_bytes(blk_q));
        enc_next   = ((round_q == NR_B) ? enc_sr : mix_cols(enc_sr)) ^ bus.rk_data;
        round_next = (round_q == 4'd0) ? (blk_q ^ bus.rk_data)
                                       : (mode_q ? dec_next : enc_next);
    end

    if (ENABLE_DEC) begin : g_dec
        localparam logic [2047:0] INV_SBOX = {
            128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
            128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
            128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
            128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
            128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
            128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
            128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
            128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
        };
        logic [127:0] isr, isb, ark;

        // Inverse round: key is added before InvMixColumns, which the last round skips.
        always_comb begin
            isr = inv_shift_rows(blk_q);
            for (int i = 0; i < 16; i++) isb[8*i +: 8] = INV_SBOX[{~isr[8*i +: 8], 3'b000} +: 8];
            ark      = isb ^ bus.rk_data;
            dec_next = (round_q == NR_B) ? ark : inv_mix_cols(ark);
        end
    end else begin : g_no_dec
        assign dec_next = '0;
    end

    // Next-state: a new block may be taken in IDLE or on the DONE hand-off edge.
    always_comb begin
        in_ready_c = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
        accept_c   = bus.in_valid && in_ready_c;
        state_d    = state_q;
        round_d    = round_q;
        mode_d     = mode_q;
        blk_d      = blk_q;
        unique case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_RUN: begin
                blk_d = round_next;
                if (round_q == NR_B) begin
                    state_d = S_DONE;
                    round_d = 4'd0;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (accept_c) begin
            blk_d   = bus.in_data;
            mode_d  = ENABLE_DEC && bus.in_mode;
            round_d = 4'd0;
            state_d = S_RUN;
        end
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            round_q     <= 4'd0;
            mode_q      <= 1'b0;
            blk_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            mode_q      <= mode_d;
            blk_q       <= blk_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.rk_no     = mode_q ? (NR_B - round_q) : round_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = blk_q;
    assign bus.out_mode  = mode_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed FIPS-197 vectors on four engine builds (128 enc/dec, 192, 256, 128 enc-only),
// with a key store expanded from a field-arithmetic S-box built at time zero.
module tb_aes_cipher_iter;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   in_valid_v, in_mode_v, out_ready_v;
    logic [127:0] in_data_v [4];
    logic [3:0]   in_ready_v, out_valid_v, out_mode_v, busy_v;
    logic [3:0]   rk_no_v [4];
    logic [127:0] out_data_v [4];
    logic [127:0] rk_tbl [4][16];
    logic [7:0]   sbox_tb [256];
    int           n_checks = 0;
    int           n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned KS = (g == 1) ? 192 : (g == 2) ? 256 : 128;
        aes_cipher_iter_if bus_if ();
        aes_cipher_iter #(.KEY_S(KS), .ENABLE_DEC(g != 3)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus_if)
        );
        assign bus_if.in_valid  = in_valid_v[g];
        assign bus_if.in_data   = in_data_v[g];
        assign bus_if.in_mode   = in_mode_v[g];
        assign bus_if.out_ready = out_ready_v[g];
        assign bus_if.rk_data   = rk_tbl[g][bus_if.rk_no];
        assign in_ready_v[g]    = bus_if.in_ready;
        assign out_valid_v[g]   = bus_if.out_valid;
        assign out_mode_v[g]    = bus_if.out_mode;
        assign busy_v[g]        = bus_if.busy;
        assign rk_no_v[g]       = bus_if.rk_no;
        assign out_data_v[g]    = bus_if.out_data;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIPS hex strings list stream byte 0 first; the engine wants it in bits [7:0].
    function automatic logic [127:0] le(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = x[8*(15-i) +: 8];
        return r;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic init_sbox();
        logic [7:0] inv, a, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            a = inv;
            s = inv;
            for (int k = 0; k < 4; k++) begin
                a = {a[6:0], a[7]};
                s ^= a;
            end
            sbox_tb[x] = s ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tb[w[31:24]], sbox_tb[w[23:16]], sbox_tb[w[15:8]], sbox_tb[w[7:0]]};
    endfunction

    // Key bytes are 00,01,02,...; word byte 0 lives in bits [7:0].
    task automatic expand_key(input int g, input int ks);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        int          nk = ks / 32;
        int          nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[7:0], t[31:8]}) ^ {24'h0, rc};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk_tbl[g][r] = (r <= nr) ? {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]} : '0;
    endtask

    task automatic start_block(input int k, input logic [127:0] d, input logic m);
        in_valid_v[k] = 1'b1;
        in_data_v[k]  = d;
        in_mode_v[k]  = m;
        #1;
        check("in_ready_at_accept", 128'(in_ready_v[k]), 128'(1));
    endtask

    // Called right after start_block; the accept cycle counts as cycle 0.
    task automatic finish_block(input int k, input logic [127:0] exp_d, input logic exp_m,
                                input int nr, input bit chk_rk);
        int lat;
        @(negedge clk);
        in_valid_v[k] = 1'b0;
        lat = 1;
        while (out_valid_v[k] !== 1'b1 && lat < 40) begin
            if (chk_rk && lat - 1 <= nr)
                check("rk_no", 128'(rk_no_v[k]), 128'(exp_m ? nr - (lat - 1) : lat - 1));
            @(negedge clk);
            lat++;
        end
        check("latency", 128'(lat), 128'(nr + 2));
        check("out_data", out_data_v[k], exp_d);
        check("out_mode", 128'(out_mode_v[k]), 128'(exp_m));
    endtask

    initial begin
        reset       = 1'b1;
        in_valid_v  = '0;
        in_mode_v   = '0;
        out_ready_v = '1;
        for (int g = 0; g < 4; g++) in_data_v[g] = '0;
        init_sbox();
        expand_key(0, 128);
        expand_key(1, 192);
        expand_key(2, 256);
        expand_key(3, 128);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int g = 0; g < 4; g++) begin
            check("rst_out_valid", 128'(out_valid_v[g]), 128'(0));
            check("rst_busy", 128'(busy_v[g]), 128'(0));
            check("rst_in_ready", 128'(in_ready_v[g]), 128'(1));
            check("rst_out_mode", 128'(out_mode_v[g]), 128'(0));
        end

        // FIPS-197 C.1/C.2/C.3 encrypt, then decrypt back on each key size.
        start_block(0, le(PT), 1'b0);
        finish_block(0, le(CT128), 1'b0, 10, 1'b1);
        start_block(1, le(PT), 1'b0);
        finish_block(1, le(CT192), 1'b0, 12, 1'b1);
        start_block(2, le(PT), 1'b0);
        finish_block(2, le(CT256), 1'b0, 14, 1'b1);
        start_block(1, le(CT192), 1'b1);
        finish_block(1, le(PT), 1'b1, 12, 1'b1);
        start_block(2, le(CT256), 1'b1);
        finish_block(2, le(PT), 1'b1, 14, 1'b1);
        @(negedge clk);

        // Encrypt-only build ignores a decrypt request.
        start_block(3, le(PT), 1'b1);
        finish_block(3, le(CT128), 1'b0, 10, 1'b1);
        @(negedge clk);

        // Backpressure in DONE, then a decrypt accepted on the release edge.
        out_ready_v[0] = 1'b0;
        start_block(0, le(PT), 1'b0);
        finish_block(0, le(CT128), 1'b0, 10, 1'b0);
        in_valid_v[0] = 1'b1;
        in_data_v[0]  = le(CT128);
        in_mode_v[0]  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 128'(out_valid_v[0]), 128'(1));
            check("bp_out_data", out_data_v[0], le(CT128));
            check("bp_in_ready", 128'(in_ready_v[0]), 128'(0));
        end
        out_ready_v[0] = 1'b1;
        start_block(0, le(CT128), 1'b1);
        finish_block(0, le(PT), 1'b1, 10, 1'b1);
        @(negedge clk);

        // Reset while the engine sits in round 4.
        start_block(0, le(PT), 1'b0);
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_rk_no", 128'(rk_no_v[0]), 128'(4));
        check("mid_in_ready", 128'(in_ready_v[0]), 128'(0));
        reset = 1'b1;
        @(negedge clk);
        check("rst2_busy", 128'(busy_v[0]), 128'(0));
        check("rst2_out_valid", 128'(out_valid_v[0]), 128'(0));
        check("rst2_in_ready", 128'(in_ready_v[0]), 128'(1));
        reset = 1'b0;
        @(negedge clk);
        start_block(0, le(PT), 1'b0);
        finish_block(0, le(CT128), 1'b0, 10, 1'b0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
